// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: shifter mode encodings and saturation limits.
package dsp_pkg;

    typedef logic [1:0] sh_mode_t;

    localparam sh_mode_t SH_LOAD       = 2'd0;
    localparam sh_mode_t SH_STORE_HIGH = 2'd1;
    localparam sh_mode_t SH_ASR        = 2'd2;
    localparam sh_mode_t SH_LSR        = 2'd3;

    // Largest positive two's-complement value of the given width (width <= 64).
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width, as a raw bit pattern.
    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// One valid/ready pipeline stage: loads when empty or when its content is being consumed.
module dsp_pipe_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_r;
    logic [DW-1:0] data_r;
    logic          advance_s;

    assign advance_s = !valid_r || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Stage occupancy and payload; payload only changes when a new item is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
        end else if (advance_s) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

endmodule

// File: rtl/dsp_shift_pipe.sv
// Two-stage scaling shifter: stage 1 rounds and does the coarse shift, stage 2 the fine
// shift, saturation and the registered result.
module dsp_shift_pipe
    import dsp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_data,
    input  logic [SHW-1:0]     sh,
    input  logic [1:0]         mode,
    input  logic               sat,
    input  logic               rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               out_ovf,
    output logic               ovf_sticky,
    input  logic               clr_ovf
);

    localparam int AW = 2 * WIDTH;
    localparam int XW = 3 * WIDTH;
    localparam int FB = (SHW >= 2) ? 2 : 1;
    localparam int P1 = XW + SHW + 3;
    localparam int P2 = AW + 1;
    localparam logic [SHW-1:0] FMASK = SHW'((32'd1 << FB) - 32'd1);

    // ---------------- stage 1: rounding add and coarse shift ----------------
    logic [SHW-1:0] coarse_s;
    logic [SHW-1:0] fine_s;
    logic [AW-1:0]  lo_sext_s;
    logic [AW:0]    radd_s;
    logic [AW:0]    rsum_s;
    logic [AW:0]    rsh_s;
    logic [XW-1:0]  w1_s;
    logic [P1-1:0]  s1_d_s;
    logic [P1-1:0]  s1_q_s;
    logic           s1_valid_s;
    logic           s2_in_ready_s;

    // Working value is 3*WIDTH wide so store-high keeps full precision through both shifts.
    always_comb begin
        coarse_s  = sh & ~FMASK;
        fine_s    = sh & FMASK;
        lo_sext_s = {{WIDTH{in_data[WIDTH-1]}}, in_data[WIDTH-1:0]};
        if (rnd && (sh != {SHW{1'b0}})) begin
            radd_s = {{AW{1'b0}}, 1'b1} << (sh - SHW'(1'b1));
        end else begin
            radd_s = {(AW+1){1'b0}};
        end
        rsum_s = {in_data[AW-1], in_data} + radd_s;
        rsh_s  = {(AW+1){1'b0}};
        case (mode)
            SH_LOAD:       w1_s = {{WIDTH{1'b0}}, lo_sext_s << coarse_s};
            SH_STORE_HIGH: w1_s = {{WIDTH{in_data[AW-1]}}, in_data} << coarse_s;
            SH_ASR: begin
                rsh_s = $signed(rsum_s) >>> coarse_s;
                w1_s  = {{(XW-AW-1){rsh_s[AW]}}, rsh_s};
            end
            SH_LSR:        w1_s = {{WIDTH{1'b0}}, in_data >> coarse_s};
            default:       w1_s = {XW{1'b0}};
        endcase
    end

    assign s1_d_s = {sat, mode, fine_s, w1_s};

    dsp_pipe_reg #(.DW(P1)) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_in_ready_s),
        .out_data  (s1_q_s)
    );

    // ---------------- stage 2: fine shift, saturation, output register ----------------
    logic [XW-1:0]  w1_q_s;
    logic [SHW-1:0] fine_q_s;
    logic [1:0]     mode_q_s;
    logic           sat_q_s;
    logic [XW-1:0]  lsh_s;
    logic [AW-1:0]  ash_s;
    logic [AW-1:0]  rsr_s;
    logic [AW-1:0]  v_s;
    logic           fits_s;
    logic [AW-1:0]  res_s;
    logic           ovf_s;
    logic [P2-1:0]  s2_q_s;

    assign w1_q_s   = s1_q_s[XW-1:0];
    assign fine_q_s = s1_q_s[XW+SHW-1:XW];
    assign mode_q_s = s1_q_s[XW+SHW+1:XW+SHW];
    assign sat_q_s  = s1_q_s[XW+SHW+2];

    // Store-high fits a signed WIDTH value when v's bits from WIDTH-1 upward are all equal.
    always_comb begin
        lsh_s  = w1_q_s << fine_q_s;
        ash_s  = AW'($signed(w1_q_s) >>> fine_q_s);
        rsr_s  = AW'(w1_q_s >> fine_q_s);
        v_s    = lsh_s[XW-1:WIDTH];
        fits_s = (&v_s[AW-1:WIDTH-1]) | ~(|v_s[AW-1:WIDTH-1]);
        ovf_s  = 1'b0;
        case (mode_q_s)
            SH_LOAD: res_s = lsh_s[AW-1:0];
            SH_STORE_HIGH: begin
                if (sat_q_s && !fits_s) begin
                    res_s = lsh_s[XW-1] ? AW'(sat_min(WIDTH)) : AW'(sat_max(WIDTH));
                    ovf_s = 1'b1;
                end else begin
                    res_s = {{WIDTH{1'b0}}, v_s[WIDTH-1:0]};
                end
            end
            SH_ASR:  res_s = ash_s;
            SH_LSR:  res_s = rsr_s;
            default: res_s = {AW{1'b0}};
        endcase
    end

    dsp_pipe_reg #(.DW(P2)) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_in_ready_s),
        .in_data   ({ovf_s, res_s}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q_s)
    );

    assign out_data = s2_q_s[AW-1:0];
    assign out_ovf  = s2_q_s[AW];

    // ---------------- sticky overflow ----------------
    logic ovf_sticky_r;
    logic ovf_set_s;

    assign ovf_set_s  = out_valid && out_ready && out_ovf;
    assign ovf_sticky = ovf_sticky_r;

    // Set has priority over clear so a consumed overflow is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_sticky_r <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky_r <= 1'b0;
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
        end
    end

endmodule

// File: tb/tb_dsp_shift_pipe.sv
// Self-checking bench for dsp_shift_pipe: directed vectors, backpressure, reset, sticky flag,
// and randomized operations checked against an arithmetic reference model.
module tb_dsp_shift_pipe;
    import dsp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic [3:0]  sh = 4'd0;
    logic [1:0]  mode = 2'd0;
    logic        sat = 1'b0;
    logic        rnd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        ovf_sticky;
    logic        clr_ovf = 1'b0;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [32:0] expq[$];
    int          cons_cyc[$];
    logic        held_v = 1'b0;
    logic [32:0] held = 33'd0;

    dsp_shift_pipe #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sh(sh), .mode(mode), .sat(sat), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers, WIDTH = 16.
    function automatic logic [32:0] model(input logic [31:0] x, input int s, input logic [1:0] m,
                                          input logic st, input logic r);
        longint xs;
        longint lo;
        longint v;
        longint t;
        logic [63:0] b;
        xs = longint'($signed(x));
        lo = longint'($signed(x[15:0]));
        case (m)
            SH_LOAD: begin
                b = 64'(lo * (longint'(1) << s));
                return {1'b0, b[31:0]};
            end
            SH_STORE_HIGH: begin
                v = (xs * (longint'(1) << s)) >>> 16;
                if (st && (v > 32767 || v < -32768))
                    return (xs < 0) ? 33'h1_0000_8000 : 33'h1_0000_7FFF;
                b = 64'(v);
                return {17'd0, b[15:0]};
            end
            SH_ASR: begin
                t = xs + ((r && s > 0) ? (longint'(1) << (s - 1)) : longint'(0));
                b = 64'(t >>> s);
                return {1'b0, b[31:0]};
            end
            default: return {1'b0, x >> s};
        endcase
    endfunction

    // Output monitor: ordered scoreboard, hold-stability, consumption timestamps.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            expq.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) chk("hold_stable", {out_ovf, out_data}, held);
            if (out_valid && out_ready) begin
                cons_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    chk("unexpected_out", {1'b0, out_valid}, 33'd0);
                end else begin
                    chk("result", {out_ovf, out_data}, expq.pop_front());
                end
            end
            held_v = out_valid && !out_ready;
            held   = {out_ovf, out_data};
        end
    end

    task automatic drive(input logic [31:0] x, input logic [3:0] s, input logic [1:0] m,
                         input logic st, input logic r);
        in_data = x; sh = s; mode = m; sat = st; rnd = r; in_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic issue(input logic [31:0] x, input logic [3:0] s, input logic [1:0] m,
                         input logic st, input logic r, input logic [32:0] exp);
        int n;
        n = 0;
        drive(x, s, m, st, r);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("accept", {32'd0, in_ready}, 33'd1);
        if (in_ready) expq.push_back(exp);
        @(posedge clk); #1;
    endtask

    task automatic rissue(input logic [31:0] x, input logic [3:0] s, input logic [1:0] m,
                          input logic st, input logic r);
        issue(x, s, m, st, r, model(x, int'(s), m, st, r));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int base;
        int n;
        #1;
        chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
        chk("rst_out", {out_ovf, out_data}, 33'd0);
        chk("rst_sticky", {32'd0, ovf_sticky}, 33'd0);
        chk("rst_in_ready", {32'd0, in_ready}, 33'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // Directed vectors, issued back to back.
        issue(32'h0000ABCD, 4'd4,  SH_LOAD,       1'b0, 1'b0, 33'h0_FFFABCD0);
        issue(32'h00001234, 4'd12, SH_LOAD,       1'b0, 1'b0, 33'h0_01234000);
        issue(32'hABCDEF09, 4'd4,  SH_STORE_HIGH, 1'b0, 1'b0, 33'h0_0000BCDE);
        issue(32'h12345678, 4'd1,  SH_STORE_HIGH, 1'b0, 1'b0, 33'h0_00002468);
        issue(32'h12345678, 4'd1,  SH_STORE_HIGH, 1'b1, 1'b0, 33'h0_00002468);
        issue(32'hFFFFFFF6, 4'd2,  SH_ASR,        1'b0, 1'b1, 33'h0_FFFFFFFE);
        issue(32'hFFFFFFF6, 4'd2,  SH_ASR,        1'b0, 1'b0, 33'h0_FFFFFFFD);
        issue(32'h7FFFFFFF, 4'd1,  SH_ASR,        1'b0, 1'b1, 33'h0_40000000);
        issue(32'h80000000, 4'd15, SH_LSR,        1'b0, 1'b1, 33'h0_00010000);
        idle(4);
        chk("sticky_before_ovf", {32'd0, ovf_sticky}, 33'd0);
        issue(32'hABCDEF09, 4'd4,  SH_STORE_HIGH, 1'b1, 1'b0, 33'h1_00008000);
        idle(1);
        chk("sticky_not_yet", {32'd0, ovf_sticky}, 33'd0);
        idle(1);
        chk("sticky_set", {32'd0, ovf_sticky}, 33'd1);

        // Clear alone, then set and clear in the same cycle.
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("sticky_clr", {32'd0, ovf_sticky}, 33'd0);
        out_ready = 1'b0;
        issue(32'h40000000, 4'd3, SH_STORE_HIGH, 1'b1, 1'b0, 33'h1_00007FFF);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out_valid", {32'd0, out_valid}, 33'd1);
        @(posedge clk); #1;
        clr_ovf = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("sticky_set_wins", {32'd0, ovf_sticky}, 33'd1);
        @(posedge clk); #1;
        chk("sticky_clr_alone", {32'd0, ovf_sticky}, 33'd0);
        clr_ovf = 1'b0;
        idle(2);

        // Backpressure: two held, third stalls, then drain in order one per cycle.
        out_ready = 1'b0;
        issue(32'h00000011, 4'd1, SH_LOAD, 1'b0, 1'b0, 33'h0_00000022);
        issue(32'h00000300, 4'd8, SH_LSR,  1'b0, 1'b0, 33'h0_00000003);
        drive(32'hFFFF0000, 4'd4, SH_ASR, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_0", {32'd0, in_ready}, 33'd0);
        chk("bp_out_valid", {32'd0, out_valid}, 33'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_in_ready_1", {32'd0, in_ready}, 33'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = cons_cyc.size();
        issue(32'hFFFF0000, 4'd4, SH_ASR,  1'b0, 1'b0, 33'h0_FFFFF000);
        issue(32'h00000001, 4'd7, SH_LOAD, 1'b0, 1'b0, 33'h0_00000080);
        idle(4);
        if (cons_cyc.size() >= base + 4)
            chk("bp_one_per_cycle", 33'(cons_cyc[base+3] - cons_cyc[base]), 33'd3);
        else
            chk("bp_drain_count", 33'(cons_cyc.size() - base), 33'd4);

        // Reset with both stages full.
        out_ready = 1'b0;
        issue(32'h00000055, 4'd0, SH_LOAD, 1'b0, 1'b0, 33'h0_00000055);
        issue(32'h00000066, 4'd0, SH_LOAD, 1'b0, 1'b0, 33'h0_00000066);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", {32'd0, out_valid}, 33'd0);
        chk("rst_mid_in_ready", {32'd0, in_ready}, 33'd1);
        chk("rst_mid_out", {out_ovf, out_data}, 33'd0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("no_stale_out", {32'd0, out_valid}, 33'd0);

        // Randomized operations with random gaps and backpressure.
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rissue($urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        chk("drain_empty", 33'(expq.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
